if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch unit of the IF stage: takes the current PC from `p_counter`, issues a word read to the synchronous instruction memory, and delivers instruction and PC+4 to the IF/ID register. It drives the return signals to the PC: `o_halt` on a HALT word and a stall-safe fetch stream. A one-entry skid buffer keeps in-flight reads from being lost under stall, and a flush input discards wrong-path fetches.

## Interface
- `IMEM_AW`, default 8: instruction-memory word-address bits (256 words).
- `RESET_PC`, default 32'h0: value of `o_pc_plus4` is `RESET_PC`+0 at reset (PC not yet fetched).
- `i_clk`  in  1  single clock, all state on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset. Clears all state.
- `i_enable`  in  1  run enable (debug step). 0 freezes the block exactly like `i_stall`.
- `i_pc`  in  32  current PC, driven by `p_counter` `o_newPC`.
- `i_stall`  in  1  hazard-unit hold.
- `i_flush`  in  1  taken branch/jump. Discard all in-flight and buffered fetches.
- `o_imem_en`  out  1  memory read strobe.
- `o_imem_addr`  out  IMEM_AW  word address = `i_pc[IMEM_AW+1:2]`.
- `i_imem_data`  in  32  read data, valid exactly 1 cycle after `o_imem_en`.
- `o_instr`  out  32  instruction to IF/ID. Reads NOP (32'h0) when `o_valid`=0.
- `o_pc_plus4`  out  32  PC of `o_instr` + 4.
- `o_valid`  out  1  `o_instr` is a new, live instruction.
- `o_halt`  out  1  sticky. Goes to `p_counter` `i_halt`.
- `o_misaligned`  out  1  sticky: a request was made with `i_pc[1:0]`≠0.
- `o_fetch_count`  out  32  instructions delivered, saturating at 32'hFFFF_FFFF.

## Operation
- States: RUN, HALTED. Reset enters RUN.
- Request (cycle t): `o_imem_en` = RUN & `i_enable` & !`i_stall` & !`i_flush`. The block latches request-valid and `i_pc` into the in-flight register.
- Response (cycle t+1):
  - Not held (stall=0, enable=1): data registers into `o_instr`/`o_pc_plus4`/`o_valid`=1, visible at t+2.
  - Held: data goes into the skid buffer. Outputs keep their prior values.
- Release after a hold: the skid entry is delivered first (next cycle). A new request issues in the same cycle, so the stream has no gap, loss or duplicate. A new request can never coincide with a full skid plus in-flight; the skid capacity of one is sufficient.
- While held, `o_valid` holds its value. IF/ID ignores it under stall.
- Flush beats stall and enable:
  - Next cycle: `o_valid`=0 and `o_instr`=0.
  - The in-flight request and the skid entry are dropped.
  - No request is issued in the flush cycle.
- HALT (`i_imem_data`=32'hFFFF_FFFF being delivered):
  - The halt word is delivered with `o_valid`=1, and `o_halt`=1 in that same cycle.
  - State goes to HALTED. No further requests are issued and the in-flight request is discarded.
- Halt word and `i_flush` captured in the same cycle: the word is dropped, there is no halt, and the state stays RUN.
- `o_fetch_count` increments once per cycle in which a new instruction is delivered. This includes the halt word and excludes held cycles.
- `o_misaligned` sets when a request is made with `i_pc[1:0]`≠0. The request still issues with the truncated address.
- HALTED clears only on reset.

## Timing
- Reset values:
  - `o_valid`=0, `o_instr`=0, `o_pc_plus4`=`RESET_PC`.
  - `o_halt`=0, `o_misaligned`=0, `o_fetch_count`=0.
  - `o_imem_en`=0 while reset is asserted.
  - Skid and in-flight registers are empty.
- Fetch latency: PC at cycle t gives the instruction on `o_instr` at t+2. Throughput is one per cycle.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first request issues on the first edge after deassertion.
- `o_pc_plus4` uses 32-bit modulo arithmetic: 32'hFFFF_FFFC yields 32'h0.

## Structure
- Package `if_pkg`:
  - `HALT_WORD` = 32'hFFFF_FFFF.
  - `NOP_WORD` = 32'h0.
  - state enum {RUN, HALTED}.
- Sub-module `if_skid_buffer`: one entry holding {instr, pc}, with load/unload/clear. `if_fetch_unit` instantiates it once.

## Test plan
- Reset: hold `i_reset`=0 for 3 cycles with garbage on `i_pc`. Required: all outputs at reset values and `o_imem_en`=0.
- Straight line: memory 0x0=A, 0x4=B, 0x8=C; PC 0, 4, 8 on consecutive cycles. Required: A, B, C appear at cycles 2–4, `o_pc_plus4` = 4, 8, 12, and count=3.
- Stall for 3 cycles while B is in flight. Required: A held, B appears the cycle after release, C follows, and count=3 with no duplicates.
- Flush while B is in flight and B is in the skid buffer. Required: `o_valid`=0 next cycle, B never appears, and the word at redirected PC 0x40 is delivered 2 cycles later.
- HALT word at 0x8. Required: `o_halt`=1 together with `o_instr`=FFFF_FFFF, `o_imem_en` stays 0 afterwards, and count frozen at 3. Variant with flush coincident with the halt word: no halt.
- Reset pulse while HALTED, then PC 0. Required: all flags cleared and A delivered 2 cycles after the first request.

Source files
------------

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and types for the instruction-fetch unit
//
// Purpose: special instruction words, the fetch FSM state encoding and the
// {instr, pc} record that is held in the skid buffer.
// Ports: none (package).

package if_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_skid_buffer.sv
// rtl/if_skid_buffer.sv - one-entry holding register for a fetch response caught by a stall
//
// Purpose: parks one {instr, pc} pair that came back from memory while the
// fetch stream was held, so it can be delivered first on release.
// Ports:
//   i_clk, i_reset  clock, asynchronous active-low reset
//   i_load          capture i_entry (marks the buffer full)
//   i_unload        entry consumed this cycle (marks the buffer empty)
//   i_clear         drop the entry (highest priority)
//   i_entry         data to capture
//   o_full          buffer holds a live entry
//   o_entry         held entry

module if_skid_buffer
  import if_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_unload,
  input  logic         i_clear,
  input  fetch_entry_t i_entry,
  output logic         o_full,
  output fetch_entry_t o_entry
);

  logic         full_q, full_d;
  fetch_entry_t entry_q, entry_d;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (i_clear) begin
      full_d = 1'b0;
    end else if (i_load) begin
      full_d  = 1'b1;
      entry_d = i_entry;
    end else if (i_unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign o_full  = full_q;
  assign o_entry = entry_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF-stage fetch unit: imem request, skid buffering, flush and halt
//
// Purpose: issues one word read per cycle from i_pc, delivers the instruction
// and PC+4 to IF/ID two cycles later, keeps in-flight data across stalls via a
// one-entry skid buffer, discards wrong-path fetches on flush and stops on the
// HALT word.
// Ports:
//   i_clk, i_reset             clock, asynchronous active-low reset
//   i_enable, i_stall          run enable / hazard hold (either freezes the block)
//   i_flush                    discard in-flight and buffered fetches
//   i_pc                       PC to fetch
//   o_imem_en, o_imem_addr     memory read strobe and word address
//   i_imem_data                read data, one cycle after o_imem_en
//   o_instr, o_pc_plus4        delivered instruction and its PC+4
//   o_valid                    o_instr is a new instruction
//   o_halt, o_misaligned       sticky status flags
//   o_fetch_count              saturating count of delivered instructions

module if_fetch_unit
  import if_pkg::*;
#(
  parameter int          IMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [31:0]        i_pc,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic               o_imem_en,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic [31:0]        i_imem_data,
  output logic [31:0]        o_instr,
  output logic [31:0]        o_pc_plus4,
  output logic               o_valid,
  output logic               o_halt,
  output logic               o_misaligned,
  output logic [31:0]        o_fetch_count
);

  if_state_e    state_q, state_d;
  logic         infl_valid_q, infl_valid_d;
  logic [31:0]  infl_pc_q, infl_pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic         halt_q, halt_d;
  logic         misaligned_q, misaligned_d;
  logic [31:0]  fetch_cnt_q, fetch_cnt_d;

  logic         held;
  logic         imem_en;
  logic         skid_load, skid_unload, skid_clear, skid_full;
  fetch_entry_t skid_in, skid_out;
  logic         deliver;
  logic [31:0]  dlv_instr, dlv_pc;

  if_skid_buffer u_skid (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (skid_load),
    .i_unload (skid_unload),
    .i_clear  (skid_clear),
    .i_entry  (skid_in),
    .o_full   (skid_full),
    .o_entry  (skid_out)
  );

  always_comb begin
    state_d      = state_q;
    infl_valid_d = 1'b0;
    infl_pc_d    = infl_pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    halt_d       = halt_q;
    misaligned_d = misaligned_q;
    fetch_cnt_d  = fetch_cnt_q;

    held = i_stall | ~i_enable;
    // Gating with i_reset keeps the strobe low while reset is asserted.
    imem_en = i_reset & (state_q == RUN) & ~held & ~i_flush;

    // A response that lands while held is parked; on release the parked entry
    // goes first. The in-flight slot is always empty then, because no request
    // issues during a hold, so skid and in-flight never compete.
    skid_in     = '{instr: i_imem_data, pc: infl_pc_q};
    skid_load   = infl_valid_q & held & ~i_flush;
    skid_unload = skid_full & ~held & ~i_flush;
    skid_clear  = i_flush;

    deliver   = ~i_flush & ~held & (skid_full | infl_valid_q);
    dlv_instr = skid_full ? skid_out.instr : i_imem_data;
    dlv_pc    = skid_full ? skid_out.pc    : infl_pc_q;

    if (imem_en) begin
      infl_valid_d = 1'b1;
      infl_pc_d    = i_pc;
      if (i_pc[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
      end
    end

    if (i_flush) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (held) begin
      valid_d = valid_q;
    end else if (deliver) begin
      valid_d    = 1'b1;
      instr_d    = dlv_instr;
      pc_plus4_d = dlv_pc + 32'd4;
      if (fetch_cnt_q != 32'hFFFF_FFFF) begin
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (dlv_instr == HALT_WORD) begin
        halt_d       = 1'b1;
        state_d      = HALTED;
        // The request issued alongside the halt word is wrong-path.
        infl_valid_d = 1'b0;
      end
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= RUN;
      infl_valid_q <= 1'b0;
      infl_pc_q    <= 32'h0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_WORD;
      pc_plus4_q   <= RESET_PC;
      halt_q       <= 1'b0;
      misaligned_q <= 1'b0;
      fetch_cnt_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      infl_valid_q <= infl_valid_d;
      infl_pc_q    <= infl_pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_plus4_q   <= pc_plus4_d;
      halt_q       <= halt_d;
      misaligned_q <= misaligned_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign o_imem_en     = imem_en;
  assign o_imem_addr   = i_pc[IMEM_AW+1:2];
  assign o_instr       = instr_q;
  assign o_pc_plus4    = pc_plus4_q;
  assign o_valid       = valid_q;
  assign o_halt        = halt_q;
  assign o_misaligned  = misaligned_q;
  assign o_fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - table-driven self-checking bench for if_fetch_unit

module tb_if_fetch_unit;

  localparam int          AW  = 8;
  localparam logic [31:0] RPC = 32'h0;

  localparam logic [31:0] A    = 32'hA000_000A;
  localparam logic [31:0] B    = 32'hB000_000B;
  localparam logic [31:0] C    = 32'hC000_000C;
  localparam logic [31:0] F    = 32'hF00D_0003;
  localparam logic [31:0] D    = 32'hD000_000D;
  localparam logic [31:0] E    = 32'hE000_000E;
  localparam logic [31:0] W    = 32'h5A5A_00FF;
  localparam logic [31:0] HLT  = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_enable = 1'b1;
  logic [31:0]   i_pc = 32'h0;
  logic          i_stall = 1'b0;
  logic          i_flush = 1'b0;
  logic          o_imem_en;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   i_imem_data = 32'h0;
  logic [31:0]   o_instr;
  logic [31:0]   o_pc_plus4;
  logic          o_valid;
  logic          o_halt;
  logic          o_misaligned;
  logic [31:0]   o_fetch_count;

  logic [31:0]   mem [0:255];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (o_imem_en) i_imem_data <= mem[o_imem_addr];
  end

  if_fetch_unit #(.IMEM_AW(AW), .RESET_PC(RPC)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_pc          (i_pc),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .o_imem_en     (o_imem_en),
    .o_imem_addr   (o_imem_addr),
    .i_imem_data   (i_imem_data),
    .o_instr       (o_instr),
    .o_pc_plus4    (o_pc_plus4),
    .o_valid       (o_valid),
    .o_halt        (o_halt),
    .o_misaligned  (o_misaligned),
    .o_fetch_count (o_fetch_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        en;
    logic        x_en;
    logic [7:0]  x_addr;
    logic        x_valid;
    logic [31:0] x_instr;
    logic [31:0] x_pc4;
    logic [31:0] x_cnt;
    logic        x_halt;
    logic        x_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] pc, logic stall, logic flush, logic en,
                              logic x_en, logic [7:0] x_addr, logic x_valid,
                              logic [31:0] x_instr, logic [31:0] x_pc4,
                              logic [31:0] x_cnt, logic x_halt, logic x_mis);
    vec_t v;
    v.pc = pc; v.stall = stall; v.flush = flush; v.en = en;
    v.x_en = x_en; v.x_addr = x_addr; v.x_valid = x_valid; v.x_instr = x_instr;
    v.x_pc4 = x_pc4; v.x_cnt = x_cnt; v.x_halt = x_halt; v.x_mis = x_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " imem_en"},    {31'b0, o_imem_en},    32'h0);
    check({tag, " valid"},      {31'b0, o_valid},      32'h0);
    check({tag, " instr"},      o_instr,               32'h0);
    check({tag, " pc_plus4"},   o_pc_plus4,            RPC);
    check({tag, " halt"},       {31'b0, o_halt},       32'h0);
    check({tag, " misaligned"}, {31'b0, o_misaligned}, 32'h0);
    check({tag, " count"},      o_fetch_count,         32'h0);
  endtask

  // Called #1 after a rising edge; reset asserts away from the edge so the
  // first checks observe the asynchronous clear.
  task automatic do_reset(input string tag);
    i_reset  = 1'b0;
    i_enable = 1'b1;
    i_stall  = 1'b0;
    i_flush  = 1'b0;
    i_pc     = 32'hDEAD_BEE3;
    #1;
    check_reset_outputs($sformatf("%s async", tag));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_reset_outputs($sformatf("%s cyc%0d", tag, k));
    end
    i_reset = 1'b1;
  endtask

  task automatic run_table(input string tname);
    foreach (vecs[i]) begin
      i_pc     = vecs[i].pc;
      i_stall  = vecs[i].stall;
      i_flush  = vecs[i].flush;
      i_enable = vecs[i].en;
      #1;
      check($sformatf("%s[%0d] imem_en", tname, i), {31'b0, o_imem_en}, {31'b0, vecs[i].x_en});
      if (vecs[i].x_en)
        check($sformatf("%s[%0d] imem_addr", tname, i), {24'b0, o_imem_addr}, {24'b0, vecs[i].x_addr});
      @(posedge clk); #1;
      check($sformatf("%s[%0d] valid", tname, i),    {31'b0, o_valid},      {31'b0, vecs[i].x_valid});
      check($sformatf("%s[%0d] instr", tname, i),    o_instr,               vecs[i].x_instr);
      check($sformatf("%s[%0d] pc_plus4", tname, i), o_pc_plus4,            vecs[i].x_pc4);
      check($sformatf("%s[%0d] count", tname, i),    o_fetch_count,         vecs[i].x_cnt);
      check($sformatf("%s[%0d] halt", tname, i),     {31'b0, o_halt},       {31'b0, vecs[i].x_halt});
      check($sformatf("%s[%0d] misaligned", tname, i), {31'b0, o_misaligned}, {31'b0, vecs[i].x_mis});
    end
    vecs.delete();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[0] = A; mem[1] = B; mem[2] = C; mem[3] = F;
    mem[16] = D; mem[17] = E; mem[255] = W;

    do_reset("reset0");

    // Straight line; misaligned PC 0xD still fetches word 3; flush drops F.
    vecs.push_back(mk(32'h0, 0, 0, 1, 1, 8'd0, 0, 32'h0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(32'h4, 0, 0, 1, 1, 8'd1, 1, A, 32'h4, 1, 0, 0));
    vecs.push_back(mk(32'h8, 0, 0, 1, 1, 8'd2, 1, B, 32'h8, 2, 0, 0));
    vecs.push_back(mk(32'hD, 0, 0, 1, 1, 8'd3, 1, C, 32'hC, 3, 0, 1));
    vecs.push_back(mk(32'h0, 0, 1, 1, 0, 8'd0, 0, 32'h0, 32'hC, 3, 0, 1));
    run_table("straight");

    // Hold for 3 cycles (one via enable=0) while B is in flight.
    do_reset("reset1");
    vecs.push_back(mk(32'h0, 0, 0, 1, 1, 8'd0, 0, 32'h0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(32'h4, 0, 0, 1, 1, 8'd1, 1, A, 32'h4, 1, 0, 0));
    vecs.push_back(mk(32'h8, 1, 0, 1, 0, 8'd0, 1, A, 32'h4, 1, 0, 0));
    vecs.push_back(mk(32'h8, 0, 0, 0, 0, 8'd0, 1, A, 32'h4, 1, 0, 0));
    vecs.push_back(mk(32'h8, 1, 0, 1, 0, 8'd0, 1, A, 32'h4, 1, 0, 0));
    vecs.push_back(mk(32'h8, 0, 0, 1, 1, 8'd2, 1, B, 32'h8, 2, 0, 0));
    vecs.push_back(mk(32'hC, 0, 0, 1, 1, 8'd3, 1, C, 32'hC, 3, 0, 0));
    vecs.push_back(mk(32'h0, 0, 1, 1, 0, 8'd0, 0, 32'h0, 32'hC, 3, 0, 0));
    run_table("stall");

    // Flush with B parked in the skid, then flush with E in flight.
    do_reset("reset2");
    vecs.push_back(mk(32'h0,  0, 0, 1, 1, 8'd0,  0, 32'h0, 32'h0,  0, 0, 0));
    vecs.push_back(mk(32'h4,  0, 0, 1, 1, 8'd1,  1, A,     32'h4,  1, 0, 0));
    vecs.push_back(mk(32'h8,  1, 0, 1, 0, 8'd0,  1, A,     32'h4,  1, 0, 0));
    vecs.push_back(mk(32'h8,  1, 1, 1, 0, 8'd0,  0, 32'h0, 32'h4,  1, 0, 0));
    vecs.push_back(mk(32'h40, 0, 0, 1, 1, 8'd16, 0, 32'h0, 32'h4,  1, 0, 0));
    vecs.push_back(mk(32'h44, 0, 0, 1, 1, 8'd17, 1, D,     32'h44, 2, 0, 0));
    vecs.push_back(mk(32'h48, 0, 1, 1, 0, 8'd0,  0, 32'h0, 32'h44, 2, 0, 0));
    vecs.push_back(mk(32'h40, 0, 0, 1, 1, 8'd16, 0, 32'h0, 32'h44, 2, 0, 0));
    vecs.push_back(mk(32'h44, 0, 0, 1, 1, 8'd17, 1, D,     32'h44, 3, 0, 0));
    vecs.push_back(mk(32'h0,  0, 1, 1, 0, 8'd0,  0, 32'h0, 32'h44, 3, 0, 0));
    run_table("flush");

    // HALT word at 0x8.
    mem[2] = HLT;
    do_reset("reset3");
    vecs.push_back(mk(32'h0,  0, 0, 1, 1, 8'd0, 0, 32'h0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(32'h4,  0, 0, 1, 1, 8'd1, 1, A,     32'h4, 1, 0, 0));
    vecs.push_back(mk(32'h8,  0, 0, 1, 1, 8'd2, 1, B,     32'h8, 2, 0, 0));
    vecs.push_back(mk(32'hC,  0, 0, 1, 1, 8'd3, 1, HLT,   32'hC, 3, 1, 0));
    vecs.push_back(mk(32'hC,  0, 0, 1, 0, 8'd0, 0, 32'h0, 32'hC, 3, 1, 0));
    vecs.push_back(mk(32'h10, 0, 0, 1, 0, 8'd0, 0, 32'h0, 32'hC, 3, 1, 0));
    run_table("halt");

    // Reset while HALTED, restart from 0, and PC+4 wrap at 0xFFFF_FFFC.
    do_reset("reset4");
    vecs.push_back(mk(32'h0,         0, 0, 1, 1, 8'd0,   0, 32'h0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(32'h4,         0, 0, 1, 1, 8'd1,   1, A,     32'h4, 1, 0, 0));
    vecs.push_back(mk(32'hFFFF_FFFC, 0, 0, 1, 1, 8'hFF,  1, B,     32'h8, 2, 0, 0));
    vecs.push_back(mk(32'h0,         0, 0, 1, 1, 8'd0,   1, W,     32'h0, 3, 0, 0));
    vecs.push_back(mk(32'h0,         0, 1, 1, 0, 8'd0,   0, 32'h0, 32'h0, 3, 0, 0));
    run_table("restart");

    // Flush coincident with the halt word: no halt, stays in RUN.
    do_reset("reset5");
    vecs.push_back(mk(32'h0, 0, 0, 1, 1, 8'd0, 0, 32'h0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(32'h4, 0, 0, 1, 1, 8'd1, 1, A,     32'h4, 1, 0, 0));
    vecs.push_back(mk(32'h8, 0, 0, 1, 1, 8'd2, 1, B,     32'h8, 2, 0, 0));
    vecs.push_back(mk(32'hC, 0, 1, 1, 0, 8'd0, 0, 32'h0, 32'h8, 2, 0, 0));
    vecs.push_back(mk(32'h0, 0, 0, 1, 1, 8'd0, 0, 32'h0, 32'h8, 2, 0, 0));
    vecs.push_back(mk(32'h4, 0, 0, 1, 1, 8'd1, 1, A,     32'h4, 3, 0, 0));
    vecs.push_back(mk(32'h0, 0, 1, 1, 0, 8'd0, 0, 32'h0, 32'h4, 3, 0, 0));
    run_table("halt_flush");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
